// File: rtl/vec_pkg.sv
// Shared definitions for the sequential vector controllers.
package vec_pkg;

  // Controller state, also used by sibling vector controllers.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Element index width; at least one bit so a single-element build stays legal.
  function automatic int idx_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain WIDTH-bit adder. The carry-out is dropped, so the result wraps modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/vector_add_seq.sv
// Element-wise vector adder. A single shared adder handles one element per
// cycle. Operands are captured on accept and the sum is held until it is taken.
module vector_add_seq
  import vec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              a [LEN],
  input  logic [WIDTH-1:0]              b [LEN],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              sum [LEN],
  output logic                          busy,
  output logic [idx_width(LEN)-1:0]     elem_idx
);

  localparam int            IW   = idx_width(LEN);
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  state_t           state_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] a_r   [LEN];
  logic [WIDTH-1:0] b_r   [LEN];
  logic [WIDTH-1:0] sum_r [LEN];
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [WIDTH-1:0] add_a_s;
  logic [WIDTH-1:0] add_b_s;
  logic [WIDTH-1:0] add_sum_s;

  // Route the current element's operands to the shared adder.
  always_comb begin
    add_a_s = a_r[idx_r];
    add_b_s = b_r[idx_r];
  end

  adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a  (add_a_s),
    .b  (add_b_s),
    .sum(add_sum_s)
  );

  // Controller: accept operands, sum one element per cycle, then hold the result until it is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < LEN; i++) begin
        a_r[i]   <= {WIDTH{1'b0}};
        b_r[i]   <= {WIDTH{1'b0}};
        sum_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            idx_r      <= {IW{1'b0}};
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        BUSY: begin
          sum_r[idx_r] <= add_sum_s;
          if (idx_r == LAST) begin
            idx_r       <= {IW{1'b0}};
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= {IW{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign elem_idx  = idx_r;
  assign sum       = sum_r;

endmodule

// File: tb/tb_vector_add_seq.sv
// Self-checking bench for vector_add_seq: an 8-element build plus a 1-element build.
module tb_vector_add_seq;

  localparam int W = 32;
  localparam int L = 8;

  typedef logic [L-1:0][W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a [L];
  logic [W-1:0] b [L];
  logic [W-1:0] sum [L];
  logic [2:0]   elem_idx;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [W-1:0] a1 [1];
  logic [W-1:0] b1 [1];
  logic [W-1:0] sum1 [1];
  logic [0:0]   elem_idx1;

  vec_t         sb_q [$];
  logic [W-1:0] sb1_q [$];
  int           n_checks = 0;
  int           n_fails  = 0;

  always #5 clk = ~clk;

  vector_add_seq #(.WIDTH(W), .LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy), .elem_idx(elem_idx)
  );

  vector_add_seq #(.WIDTH(W), .LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .busy(busy1), .elem_idx(elem_idx1)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair, push the expected sum to the scoreboard, take the accept edge.
  task automatic send(input vec_t va, input vec_t vb);
    vec_t exp_v;
    for (int i = 0; i < L; i++) begin
      a[i]     = va[i];
      b[i]     = vb[i];
      exp_v[i] = va[i] + vb[i];
    end
    sb_q.push_back(exp_v);
    in_valid = 1'b1;
    check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    check_eq("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    check_eq("elem_idx_after_accept", {29'd0, elem_idx}, 32'd0);
  endtask

  // Wait (bounded) for out_valid, tracking elem_idx, then compare against the scoreboard head.
  task automatic wait_result();
    int   lat;
    vec_t exp_v;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 3 * L) begin
      step();
      lat++;
      if (out_valid !== 1'b1 && lat < L)
        check_eq($sformatf("elem_idx_at_%0d", lat), {29'd0, elem_idx}, W'(lat));
    end
    check_eq("latency", W'(lat), W'(L));
    if (sb_q.size() > 0) begin
      exp_v = sb_q[0];
      for (int i = 0; i < L; i++)
        check_eq($sformatf("sum[%0d]", i), sum[i], exp_v[i]);
    end else begin
      check_eq("scoreboard_nonempty", 32'd0, 32'd1);
    end
  endtask

  // Complete the output handshake and retire the scoreboard entry.
  task automatic handshake();
    out_ready = 1'b1;
    step();
    check_eq("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    check_eq("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    check_eq("busy_after_take", {31'd0, busy}, 32'd0);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  initial begin
    vec_t va, vb, exp_v;
    int   cnt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1[0] = 32'd0; b1[0] = 32'd0;
    for (int i = 0; i < L; i++) begin a[i] = 32'd0; b[i] = 32'd0; end
    step(); step();
    rst_n = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 5; c++) begin
      check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < L; i++) check_eq("idle_sum", sum[i], 32'd0);
      step();
    end

    // a[i]=i, b[i]=10*i with out_ready held high throughout.
    out_ready = 1'b1;
    for (int i = 0; i < L; i++) begin va[i] = W'(i); vb[i] = W'(10 * i); end
    send(va, vb);
    wait_result();
    for (int i = 0; i < L; i++) check_eq("sum_11i", sum[i], W'(11 * i));
    handshake();

    // Wrap-around: all-ones plus i+1 gives i.
    for (int i = 0; i < L; i++) begin va[i] = 32'hFFFF_FFFF; vb[i] = W'(i + 1); end
    send(va, vb);
    wait_result();
    for (int i = 0; i < L; i++) check_eq("sum_wrap", sum[i], W'(i));
    handshake();

    // Held in DONE with noisy inputs; the sum must stay put.
    out_ready = 1'b0;
    for (int i = 0; i < L; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    send(va, vb);
    wait_result();
    exp_v = sb_q[0];
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < L; i++) begin a[i] = $urandom; b[i] = $urandom; end
      step();
      check_eq("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < L; i++) check_eq("hold_sum", sum[i], exp_v[i]);
    end
    in_valid = 1'b0;
    handshake();
    out_ready = 1'b0;
    step();
    check_eq("idle_after_pulse", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a computation.
    for (int i = 0; i < L; i++) begin va[i] = W'(100 + i); vb[i] = W'(7); end
    send(va, vb);
    cnt = 0;
    while (elem_idx != 3'd4 && cnt < 20) begin step(); cnt++; end
    check_eq("reached_idx4", {29'd0, elem_idx}, 32'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_elem_idx", {29'd0, elem_idx}, 32'd0);
    for (int i = 0; i < L; i++) check_eq("rst_sum", sum[i], 32'd0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid !== 1'b0) cnt++;
    end
    check_eq("no_out_valid_after_rst", W'(cnt), 32'd0);

    out_ready = 1'b1;
    for (int i = 0; i < L; i++) begin va[i] = 32'd1; vb[i] = 32'd1; end
    send(va, vb);
    wait_result();
    for (int i = 0; i < L; i++) check_eq("sum_two", sum[i], 32'd2);
    handshake();

    // Single-element build: 5 + 7.
    a1[0] = 32'd5; b1[0] = 32'd7; sb1_q.push_back(32'd12);
    out_ready1 = 1'b1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    check_eq("len1_busy", {31'd0, busy1}, 32'd1);
    check_eq("len1_out_valid_early", {31'd0, out_valid1}, 32'd0);
    cnt = 0;
    while (out_valid1 !== 1'b1 && cnt < 10) begin step(); cnt++; end
    check_eq("len1_latency", W'(cnt), 32'd1);
    check_eq("len1_sum", sum1[0], sb1_q.pop_front());
    step();
    check_eq("len1_in_ready", {31'd0, in_ready1}, 32'd1);
    check_eq("len1_out_valid_done", {31'd0, out_valid1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
